// File: rtl/vec_mul_rr_sched.sv
// Round-robin scheduler sharing one serial dot-product MAC engine between N_REQ requesters.
// One job at a time: grant, latch operands, run engine until valid or timeout, hold response.
module vec_mul_rr_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned C       = 8,
    parameter int unsigned W_X     = 8,
    parameter int unsigned W_K     = 8,
    parameter int unsigned TIMEOUT = 32,
    localparam int unsigned IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned TW     = $clog2(TIMEOUT + 1),
    localparam int unsigned KW     = C * W_K,
    localparam int unsigned XW     = C * W_X
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*KW-1:0]    req_k,
    input  logic [N_REQ*XW-1:0]    req_x,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IW-1:0]          resp_id,
    output logic [W_X-1:0]         resp_y,
    output logic                   resp_err,
    output logic                   mac_en,
    output logic [KW-1:0]          mac_k,
    output logic [XW-1:0]          mac_x,
    input  logic                   mac_valid,
    input  logic [W_X-1:0]         mac_y,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [KW-1:0]   mac_k_q, mac_k_d;
    logic [XW-1:0]   mac_x_q, mac_x_d;
    logic [IW-1:0]   resp_id_q, resp_id_d;
    logic [W_X-1:0]  resp_y_q, resp_y_d;
    logic            resp_err_q, resp_err_d;
    logic            resp_valid_q, resp_valid_d;
    logic            mac_en_q, mac_en_d;
    logic            busy_q, busy_d;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;

    // Round-robin search starting one past the last served requester
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % N_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Next-state and output computation; req_ready is a same-cycle accept strobe
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        timer_d      = timer_q;
        mac_k_d      = mac_k_q;
        mac_x_d      = mac_x_q;
        resp_id_d    = resp_id_q;
        resp_y_d     = resp_y_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = resp_valid_q;
        mac_en_d     = mac_en_q;
        busy_d       = busy_q;
        req_ready    = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    mac_k_d            = req_k[32'(gnt_idx)*KW +: KW];
                    mac_x_d            = req_x[32'(gnt_idx)*XW +: XW];
                    resp_id_d          = gnt_idx;
                    timer_d            = '0;
                    mac_en_d           = 1'b1;
                    busy_d             = 1'b1;
                    state_d            = ST_RUN;
                end
            end
            ST_RUN: begin
                // engine result takes priority over a timeout in the same cycle
                if (mac_valid) begin
                    resp_y_d     = mac_y;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    mac_en_d     = 1'b0;
                    state_d      = ST_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    resp_y_d     = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    mac_en_d     = 1'b0;
                    state_d      = ST_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    ptr_d        = resp_id_q;
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= IW'(N_REQ - 1);
            timer_q      <= '0;
            mac_k_q      <= '0;
            mac_x_q      <= '0;
            resp_id_q    <= '0;
            resp_y_q     <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            mac_en_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
            mac_k_q      <= mac_k_d;
            mac_x_q      <= mac_x_d;
            resp_id_q    <= resp_id_d;
            resp_y_q     <= resp_y_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
            mac_en_q     <= mac_en_d;
            busy_q       <= busy_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_y     = resp_y_q;
    assign resp_err   = resp_err_q;
    assign mac_en     = mac_en_q;
    assign mac_k      = mac_k_q;
    assign mac_x      = mac_x_q;
    assign busy       = busy_q;

endmodule
